// File: rtl/i8088_bus_master_if.sv
// Host command port and 8088 minimum-mode bus signals for i8088_bus_master.
// Clock, reset and the bidirectional AD pads stay plain module ports.
interface i8088_bus_master_if;
  logic        REQ;
  logic        REQ_WR;
  logic        REQ_IO;
  logic [19:0] REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic        ACK;
  logic        DONE;
  logic [7:0]  RDATA;
  logic        ERR;
  logic        BUSY;
  logic [11:0] A;
  logic        ALE;
  logic        RD;
  logic        WR;
  logic        IOM;
  logic        DTR;
  logic        DEN;
  logic        READY;
  logic        HOLD;
  logic        HLDA;

  modport master (
    input  REQ, REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA,
    input  READY, HOLD,
    output ACK, DONE, RDATA, ERR, BUSY,
    output A, ALE, RD, WR, IOM, DTR, DEN, HLDA
  );

  modport slave (
    output REQ, REQ_WR, REQ_IO, REQ_ADDR, REQ_WDATA,
    output READY, HOLD,
    input  ACK, DONE, RDATA, ERR, BUSY,
    input  A, ALE, RD, WR, IOM, DTR, DEN, HLDA
  );
endinterface

// File: rtl/i8088_bus_master.sv
// Minimum-mode 8088 bus initiator: host byte commands to T1-T4 cycles.
// Define I8088_HOLD_EN to add HOLD/HLDA bus arbitration.
module i8088_bus_master #(
  parameter int MAX_WAIT     = 15,
  parameter int IO_ADDR_BITS = 16
) (
  input  logic               CLK,
  input  logic               RESET_N,
  i8088_bus_master_if.master bus,
  inout  wire  [7:0]         AD
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_T3,
    S_TW,
    S_T4
`ifdef I8088_HOLD_EN
    , S_HLD
`endif
  } state_t;

  typedef struct packed {
    logic        wr;
    logic        io;
    logic [19:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  typedef struct packed {
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic        den_n;
    logic        dtr;
    logic        iom;
    logic [11:0] a;
    logic [7:0]  ad;
    logic        ad_oe;
    logic        ack;
    logic        done;
    logic        err;
    logic [7:0]  rdata;
  } out_t;

  localparam logic [7:0] MW = 8'(MAX_WAIT);

  localparam logic [19:0] IO_MASK =
    (IO_ADDR_BITS >= 20) ? 20'hFFFFF :
    20'((64'd1 << IO_ADDR_BITS) - 64'd1);

  localparam out_t OUT_RST = '{
    ale:   1'b0,
    rd_n:  1'b1,
    wr_n:  1'b1,
    den_n: 1'b1,
    dtr:   1'b0,
    iom:   1'b0,
    a:     12'h000,
    ad:    8'h00,
    ad_oe: 1'b0,
    ack:   1'b0,
    done:  1'b0,
    err:   1'b0,
    rdata: 8'h00
  };

  state_t     state_q;
  state_t     state_d;
  cmd_t       cmd_q;
  cmd_t       cmd_d;
  out_t       o_q;
  out_t       o_d;
  logic [7:0] wcnt_q;
  logic [7:0] wcnt_d;
  logic       take;
  logic       tmo;

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    wcnt_d   = wcnt_q;
    o_d      = o_q;
    o_d.ack  = 1'b0;
    o_d.done = 1'b0;
    tmo      = 1'b0;
    take     = bus.REQ &&
               (state_q == S_IDLE || state_q == S_T4);

    if (take) begin
      cmd_d.wr    = bus.REQ_WR;
      cmd_d.io    = bus.REQ_IO;
      cmd_d.wdata = bus.REQ_WDATA;
      cmd_d.addr  = bus.REQ_IO ?
                    (bus.REQ_ADDR & IO_MASK) :
                    bus.REQ_ADDR;
    end

    unique case (state_q)
      S_IDLE, S_T4: begin
        if (take)
          state_d = S_T1;
`ifdef I8088_HOLD_EN
        else if (bus.HOLD)
          state_d = S_HLD;
`endif
        else
          state_d = S_IDLE;
      end
      S_T1: begin
        state_d = S_T2;
        wcnt_d  = 8'd0;
      end
      S_T2: state_d = S_T3;
      S_T3, S_TW: begin
        if (bus.READY) begin
          state_d = S_T4;
        end else if (state_q == S_TW &&
                     wcnt_q == MW) begin
          state_d = S_T4;
          tmo     = 1'b1;
        end else begin
          state_d = S_TW;
          wcnt_d  = wcnt_q + 8'd1;
        end
      end
`ifdef I8088_HOLD_EN
      S_HLD: state_d = bus.HOLD ? S_HLD : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase

    unique case (1'b1)
      state_d == S_T1: begin
        o_d.ale   = 1'b1;
        o_d.rd_n  = 1'b1;
        o_d.wr_n  = 1'b1;
        o_d.den_n = 1'b1;
        o_d.a     = cmd_d.addr[19:8];
        o_d.ad    = cmd_d.addr[7:0];
        o_d.ad_oe = 1'b1;
        o_d.iom   = cmd_d.io;
        o_d.dtr   = cmd_d.wr;
        o_d.ack   = 1'b1;
        o_d.err   = 1'b0;
      end
      state_d == S_T2,
      state_d == S_T3,
      state_d == S_TW: begin
        o_d.ale   = 1'b0;
        o_d.den_n = 1'b0;
        o_d.rd_n  = cmd_q.wr;
        o_d.wr_n  = ~cmd_q.wr;
        o_d.ad    = cmd_q.wdata;
        o_d.ad_oe = cmd_q.wr;
      end
      state_d == S_T4: begin
        o_d.rd_n  = 1'b1;
        o_d.wr_n  = 1'b1;
        o_d.den_n = 1'b1;
        o_d.ad_oe = cmd_q.wr;
        o_d.done  = 1'b1;
        o_d.err   = tmo;
        if (!cmd_q.wr)
          o_d.rdata = tmo ? 8'hFF : AD;
      end
      default: begin
        o_d.ale   = 1'b0;
        o_d.rd_n  = 1'b1;
        o_d.wr_n  = 1'b1;
        o_d.den_n = 1'b1;
        o_d.ad_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      wcnt_q  <= 8'd0;
      o_q     <= OUT_RST;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      wcnt_q  <= wcnt_d;
      o_q     <= o_d;
    end
  end

  assign AD       = o_q.ad_oe ? o_q.ad : 8'hzz;
  assign bus.ACK   = o_q.ack;
  assign bus.DONE  = o_q.done;
  assign bus.RDATA = o_q.rdata;
  assign bus.ERR   = o_q.err;
  assign bus.BUSY  = state_q != S_IDLE;
  assign bus.ALE   = o_q.ale;

`ifdef I8088_HOLD_EN
  logic hlda_q;
  logic flt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      hlda_q <= 1'b0;
    else
      hlda_q <= state_d == S_HLD;
  end

  // While another master owns the bus every shared line floats.
  assign flt      = state_q == S_HLD;
  assign bus.A    = flt ? 12'hzzz : o_q.a;
  assign bus.RD   = flt ? 1'bz : o_q.rd_n;
  assign bus.WR   = flt ? 1'bz : o_q.wr_n;
  assign bus.IOM  = flt ? 1'bz : o_q.iom;
  assign bus.DTR  = flt ? 1'bz : o_q.dtr;
  assign bus.DEN  = flt ? 1'bz : o_q.den_n;
  assign bus.HLDA = hlda_q;
`else
  logic unused_hold;

  assign unused_hold = bus.HOLD;
  assign bus.A    = o_q.a;
  assign bus.RD   = o_q.rd_n;
  assign bus.WR   = o_q.wr_n;
  assign bus.IOM  = o_q.iom;
  assign bus.DTR  = o_q.dtr;
  assign bus.DEN  = o_q.den_n;
  assign bus.HLDA = 1'b0;
`endif

endmodule

// File: tb/tb_i8088_bus_master.sv
// Bench for i8088_bus_master: latch/memory/IO peripheral model plus
// a cycle-level reference of timing, strobes, data and timeouts.
module tb_i8088_bus_master;
  localparam int MW = 4;

  logic CLK     = 1'b0;
  logic RESET_N = 1'b1;
  wire  [7:0] AD;

  i8088_bus_master_if bus ();

  i8088_bus_master #(
    .MAX_WAIT    (MW),
    .IO_ADDR_BITS(16)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus),
    .AD     (AD)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int tn     = 0;

  logic [7:0]  dev_mem [logic [20:0]];
  logic [7:0]  ref_mem [logic [20:0]];
  logic [20:0] lat    = '0;
  logic [7:0]  dev_rd = '0;

  function automatic logic [7:0] pat(input logic [20:0] k);
    return k[7:0] ^ k[15:8] ^ {3'b000, k[20:16]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] dev_get(input logic [20:0] k);
    return dev_mem.exists(k) ? dev_mem[k] : pat(k);
  endfunction

  // 8282 latch plus a byte-wide memory/IO peripheral.
  always @(negedge CLK)
    if (bus.ALE === 1'b1) begin
      lat    = {bus.IOM, bus.A, AD};
      dev_rd = dev_get({bus.IOM, bus.A, AD});
    end

  always @(posedge CLK)
    if (RESET_N && bus.WR === 1'b0)
      dev_mem[lat] = AD;

  assign AD = (bus.RD === 1'b0) ? dev_rd : 8'hzz;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (txn %0d): observed %0h expected %0h",
             tag, tn, obs, exp);
    end
  endtask

  task automatic run_cmd(input bit wr, input bit io,
                         input logic [19:0] addr,
                         input logic [7:0] wd,
                         input int k);
    int n, c, w;
    int rd_lo, wr_lo, den_lo, ale_hi, bad_hold, bad_ad, busy_lo;
    bit eerr, done;
    logic [19:0] ea;
    logic [20:0] key;
    logic [7:0]  erd;
    tn++;
    n    = (k < MW) ? k : MW;
    eerr = k > MW;
    ea   = io ? {4'h0, addr[15:0]} : addr;
    key  = {io, ea};
    erd  = eerr ? 8'hFF :
           (ref_mem.exists(key) ? ref_mem[key] : pat(key));

    @(negedge CLK);
    bus.REQ       = 1'b1;
    bus.REQ_WR    = wr;
    bus.REQ_IO    = io;
    bus.REQ_ADDR  = addr;
    bus.REQ_WDATA = wd;
    w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (bus.ACK !== 1'b1 && w < 8);
    chk("ack_latency", 32'(w), 1);
    chk("err_clear_at_ack", 32'(bus.ERR), 0);
    chk("t1_ad", 32'(AD), 32'(ea[7:0]));
    bus.REQ = 1'b0;

    c = 1; done = 1'b0;
    rd_lo = 0; wr_lo = 0; den_lo = 0; ale_hi = 0;
    bad_hold = 0; bad_ad = 0; busy_lo = 0;
    while (!done && c <= 30) begin
      ale_hi += int'(bus.ALE);
      rd_lo  += int'(!bus.RD);
      wr_lo  += int'(!bus.WR);
      den_lo += int'(!bus.DEN);
      busy_lo += int'(!bus.BUSY);
      if (bus.A !== ea[19:8] || bus.IOM !== io ||
          bus.DTR !== wr)
        bad_hold++;
      if (wr && c >= 2 && AD !== wd)
        bad_ad++;
      done = bus.DONE;
      if (!done) begin
        bus.READY = (c >= 3) ? (c >= 3 + k) : 1'($urandom);
        @(negedge CLK);
        c++;
      end
    end

    chk("done_seen", 32'(done), 1);
    chk("cycle_len", 32'(c), 32'(4 + n));
    chk("ale_clocks", 32'(ale_hi), 1);
    chk("rd_low_clocks", 32'(rd_lo), wr ? 0 : 32'(2 + n));
    chk("wr_low_clocks", 32'(wr_lo), wr ? 32'(2 + n) : 0);
    chk("den_low_clocks", 32'(den_lo), 32'(2 + n));
    chk("a_iom_dtr_held", 32'(bad_hold), 0);
    chk("busy_in_cycle", 32'(busy_lo), 0);
    chk("latched_addr", 32'(lat), 32'(key));
    chk("err", 32'(bus.ERR), 32'(eerr));
    if (wr) begin
      chk("wdata_on_ad", 32'(bad_ad), 0);
      chk("dev_store", 32'(dev_get(key)), 32'(wd));
      ref_mem[key] = wd;
    end else begin
      chk("rdata", 32'(bus.RDATA), 32'(erd));
    end
    bus.READY = 1'b1;
  endtask

  initial begin
    int w;
    bit dn;
    logic [7:0] ale_v, done_v, ack_v;
    bit rw, rio;
    logic [19:0] ra;

    bus.REQ       = 1'b0;
    bus.REQ_WR    = 1'b0;
    bus.REQ_IO    = 1'b0;
    bus.REQ_ADDR  = '0;
    bus.REQ_WDATA = '0;
    bus.READY     = 1'b1;
    bus.HOLD      = 1'b0;

    #2 RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ctrl",
        32'({bus.ALE, bus.RD, bus.WR, bus.DEN, bus.DTR,
             bus.IOM, bus.ACK, bus.DONE, bus.BUSY,
             bus.ERR, bus.HLDA}),
        32'(11'b01110000000));
    chk("rst_a", 32'(bus.A), 0);
    chk("rst_rdata", 32'(bus.RDATA), 0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("idle_busy", 32'(bus.BUSY), 0);

    run_cmd(1'b0, 1'b0, 20'h80123, 8'h00, 0);
    run_cmd(1'b1, 1'b1, 20'h0FF05, 8'h5A, 0);
    run_cmd(1'b0, 1'b1, 20'hAFF05, 8'h00, 0);
    run_cmd(1'b0, 1'b0, 20'h80123, 8'h00, 3);
    run_cmd(1'b0, 1'b0, 20'h00777, 8'h00, 20);
    @(negedge CLK);
    chk("err_held_idle", 32'(bus.ERR), 1);
    run_cmd(1'b1, 1'b0, 20'h00777, 8'h99, MW);
    run_cmd(1'b0, 1'b0, 20'h00777, 8'h00, MW + 1);
    run_cmd(1'b0, 1'b0, 20'h00777, 8'h00, 1);

    // Back-to-back: write then read of the same byte, REQ held.
    tn++;
    @(negedge CLK);
    bus.REQ       = 1'b1;
    bus.REQ_WR    = 1'b1;
    bus.REQ_IO    = 1'b0;
    bus.REQ_ADDR  = 20'h12345;
    bus.REQ_WDATA = 8'hC3;
    w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (bus.ACK !== 1'b1 && w < 8);
    chk("b2b_ack", 32'(w), 1);
    ale_v = '0; done_v = '0; ack_v = '0;
    for (int c = 1; c <= 8; c++) begin
      ale_v[c-1]  = bus.ALE;
      done_v[c-1] = bus.DONE;
      ack_v[c-1]  = bus.ACK;
      if (c == 1) begin
        bus.REQ_WR    = 1'b0;
        bus.REQ_WDATA = 8'h00;
      end
      if (c == 5) bus.REQ = 1'b0;
      if (c < 8) @(negedge CLK);
    end
    chk("b2b_ale", 32'(ale_v), 32'(8'b0001_0001));
    chk("b2b_done", 32'(done_v), 32'(8'b1000_1000));
    chk("b2b_ack_pulses", 32'(ack_v), 32'(8'b0001_0001));
    chk("b2b_rdata", 32'(bus.RDATA), 32'(8'hC3));
    ref_mem[{1'b0, 20'h12345}] = 8'hC3;

    for (int i = 0; i < 40; i++) begin
      rw  = 1'($urandom_range(0, 1));
      rio = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 1) == 1) ?
            20'($urandom) :
            {4'($urandom), 12'h0AB, 4'($urandom_range(0, 3))};
      run_cmd(rw, rio, ra, 8'($urandom),
              int'($urandom_range(0, 6)));
    end

    // Reset in the middle of T3 of a read.
    tn++;
    @(negedge CLK);
    bus.REQ      = 1'b1;
    bus.REQ_WR   = 1'b0;
    bus.REQ_IO   = 1'b0;
    bus.REQ_ADDR = 20'h00333;
    bus.READY    = 1'b0;
    w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (bus.ACK !== 1'b1 && w < 8);
    bus.REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("mid_rd_active", 32'(bus.RD), 0);
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_strobes",
        32'({bus.RD, bus.WR, bus.DEN, bus.ALE}),
        32'(4'b1110));
    chk("mid_rst_busy", 32'(bus.BUSY), 0);
    chk("mid_rst_rdata", 32'(bus.RDATA), 0);
    dn = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      dn |= bus.DONE;
    end
    RESET_N   = 1'b1;
    bus.READY = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      dn |= bus.DONE;
    end
    chk("post_rst_busy", 32'(bus.BUSY), 0);
    chk("no_done_after_rst", 32'(dn), 0);
    run_cmd(1'b0, 1'b0, 20'h00333, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/i8088_bus_master.md
Name: i8088_bus_master

Overview:
- Synthesizable minimum-mode 8088 bus initiator. It turns single-byte host commands into T1–T4 bus cycles with wait states.
- Drives the shared AD/A bus plus ALE, RD, WR, IOM, DTR and DEN. Inputs and outputs match the existing memory/IO peripherals, the 8282 latch and the 8286 transceiver.
- Lets the peripheral models be driven by RTL instead of the processor model.

Parameters:
- MAX_WAIT, 15: maximum consecutive Tw states before the cycle is aborted. Legal range 1–255.
- IO_ADDR_BITS, 16: number of valid address bits in IO cycles. Bits above this are driven 0.

Ports:
- CLK  input  1  bus clock; all state changes on posedge.
- RESET_N  input  1  asynchronous, active-low reset.
- REQ  input  1  command request; level, held until ACK.
- REQ_WR  input  1  1 = write, 0 = read.
- REQ_IO  input  1  1 = IO space, 0 = memory.
- REQ_ADDR  input  20  byte address.
- REQ_WDATA  input  8  write data.
- ACK  output  1  one-cycle pulse when the command is captured.
- DONE  output  1  one-cycle pulse in T4.
- RDATA  output  8  read data; valid from DONE until the next DONE.
- ERR  output  1  set with DONE when the cycle timed out; cleared at the next ACK.
- BUSY  output  1  high whenever state != IDLE.
- AD  inout  8  multiplexed address/data.
- A  output  12  address bits 19:8.
- ALE  output  1  address latch enable, active high.
- RD  output  1  read strobe, active low.
- WR  output  1  write strobe, active low.
- IOM  output  1  1 = IO, 0 = memory.
- DTR  output  1  1 = transmit (write), 0 = receive.
- DEN  output  1  data enable, active low.
- READY  input  1  wait-state request from the peripheral; low inserts Tw.
- HOLD  input  1  bus request; used only with the optional feature.
- HLDA  output  1  hold acknowledge.

Behaviour:
- **Reset.** RESET_N low forces, immediately and asynchronously:
  - state IDLE; AD = Z; A = 0.
  - ALE = 0, RD = 1, WR = 1, DEN = 1, DTR = 0, IOM = 0.
  - ACK = 0, DONE = 0, BUSY = 0, ERR = 0, HLDA = 0, RDATA = 0x00.
  - This applies mid-cycle too: the aborted cycle produces no DONE.
- **Clocking.** All bus outputs are registered. Outputs listed for a state are valid for that whole clock period.
- **States.** IDLE, T1, T2, T3, TW, T4, plus HOLD with the optional feature.
- **Command capture.** The command is captured on a posedge where REQ = 1 and the state is IDLE or T4. ACK pulses in the following cycle, which is T1. Back-to-back commands therefore give continuous 4-clock cycles with no idle gap. REQ while in T1–TW is ignored.
- **T1.**
  - ALE = 1, AD = addr[7:0], A = addr[19:8].
  - IO cycles: bits at and above IO_ADDR_BITS are driven 0.
  - IOM = REQ_IO, DTR = REQ_WR. RD, WR and DEN stay inactive.
- **T2.** ALE = 0, A held, DEN = 0.
  - Write: AD = wdata, WR = 0.
  - Read: AD = Z, RD = 0.
- **T3 / TW.** Outputs as in T2. READY is sampled at the end of each T3/TW.
  - READY = 1: go to T4. A read captures AD into RDATA on the same edge.
  - READY = 0: go to TW and increment the wait counter.
- **Timeout.** If the wait counter reaches MAX_WAIT with READY = 0, go to T4 with ERR = 1. RDATA = 0xFF on a read.
- **T4.**
  - RD = 1, WR = 1, DEN = 1.
  - Write: AD keeps driving wdata. Read: AD = Z.
  - DONE = 1; IOM, DTR and A held.
  - Next state is T1 if a new command is captured, otherwise IDLE. On entry to IDLE, A and IOM hold their last values.
- **Cycle length.** 4 + n clocks, where n is the number of Tw states.
- **AD driving.** AD is never driven in the same cycle that DEN = 0 with DTR = 0.
- **READY outside T3/TW.** Ignored.

Optional Feature:
- Macro: I8088_HOLD_EN.
- **Defined:**
  - HOLD is sampled in IDLE and T4. If HOLD = 1 and no command is captured, the next state is HOLD.
  - In HOLD: HLDA = 1, and AD, A, RD, WR, IOM, DTR and DEN are all Z. REQ is not captured.
  - HOLD = 0 sampled in HOLD: next state is IDLE, HLDA = 0, and the idle outputs are re-driven.
  - A pending REQ wins over HOLD at the same edge.
- **Undefined:** HOLD is ignored, HLDA is tied 0, and the HOLD state does not exist.

Test Plan:
- **Memory read.** REQ read, memory, addr 0x80123, READY = 1.
  - ALE high in clock 1 only; the 8282 latch holds 0x80123; IOM = 0; RD low in clocks 2–3.
  - DONE in clock 4; RDATA equals the memory byte at 0x80123; ERR = 0.
- **IO write.** REQ write, IO, addr 0xFF05, data 0x5A.
  - IOM = 1, A[19:16] = 0, DTR = 1.
  - WR low in T2–T3, AD = 0x5A in T2–T4; the peripheral at 0xFF05 stores 0x5A.
- **Wait states.** READY held low for 3 clocks from T3 → exactly 3 TW, DONE in clock 7, RD low for clocks 2–6.
- **Timeout.** MAX_WAIT = 4, READY stuck 0 on a read → 4 TW then T4, DONE with ERR = 1 and RDATA = 0xFF. ERR clears at the next ACK.
- **Back-to-back.** REQ held with a new command present at T4 → the next ALE follows the DONE clock directly, giving two 4-clock cycles in 8 clocks.
- **Reset mid-cycle.** RESET_N low in the middle of T3 → RD = 1, DEN = 1, AD = Z before the next posedge; no DONE; after release, state is IDLE and BUSY = 0.
